// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 64-bit add/sub/and/xor ALU between two requesters.
// Optional condition-code register is enabled by defining ALU_ARB_CC_EN.
module alu_arbiter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_y,
  output logic         rsp_ovf,
  output logic         busy,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]          state;
  logic                prio;
  logic                gnt0, gnt1;
  logic [1:0]          op_p0;
  logic signed [W-1:0] a_p0, b_p0;
  logic                id_p0;
  logic signed [W-1:0] y_p1;
  logic                ovf_p1;

  function automatic logic signed [W-1:0] alu_y(input logic [1:0] op,
                                                input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    case (op)
      2'd0:    alu_y = a + b;
      2'd1:    alu_y = a - b;
      2'd2:    alu_y = a & b;
      default: alu_y = a ^ b;
    endcase
  endfunction

  function automatic logic alu_ovf(input logic [1:0] op,
                                   input logic signed [W-1:0] a,
                                   input logic signed [W-1:0] b,
                                   input logic signed [W-1:0] y);
    case (op)
      2'd0:    alu_ovf = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
      2'd1:    alu_ovf = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
      default: alu_ovf = 1'b0;
    endcase
  endfunction

  // Grant is purely a function of valids, state and prio; rsp_ready never reaches it.
  always_comb begin
    gnt0 = (state == IDLE) && req0_valid && (!req1_valid || !prio);
    gnt1 = (state == IDLE) && req1_valid && (!req0_valid ||  prio);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign busy       = (state != IDLE);

  // Stage p0: capture the granted operation
  always_ff @(posedge clk) begin
    if (gnt0 || gnt1) begin
      op_p0 <= gnt1 ? req1_op : req0_op;
      a_p0  <= gnt1 ? req1_a  : req0_a;
      b_p0  <= gnt1 ? req1_b  : req0_b;
      id_p0 <= gnt1;
    end
  end

  // Stage p1: shared ALU on the captured operands
  always_comb begin
    y_p1   = alu_y(op_p0, a_p0, b_p0);
    ovf_p1 = alu_ovf(op_p0, a_p0, b_p0, y_p1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_ovf   <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            state <= EXEC;
            prio  <= gnt0;
          end
        end
        EXEC: begin
          rsp_y     <= y_p1;
          rsp_ovf   <= ovf_p1;
          rsp_id    <= id_p0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_CC_EN
  // Flags load with the result, independent of which requester owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf <= 1'b0;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (state == EXEC) begin
      cc_zf <= (y_p1 == '0);
      cc_sf <= y_p1[W-1];
      cc_of <= ovf_p1;
    end
  end
`else
  assign cc_zf = 1'b0;
  assign cc_sf = 1'b0;
  assign cc_of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and compares them on each response handshake.
module tb_alu_arbiter;
  localparam int W = 64;
`ifdef ALU_ARB_CC_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready;
  logic [1:0]   req0_op;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [1:0]   req1_op;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
  logic [W-1:0] rsp_y;
  logic         cc_zf, cc_sf, cc_of;

  typedef struct {
    logic         id;
    logic [W-1:0] y;
    logic         ovf;
    logic [2:0]   cc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_ovf(rsp_ovf), .busy(busy),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [W-1:0] y, input logic ovf,
                      input logic zf, input logic sf, input logic of_);
    exp_t e;
    e.id  = id;
    e.y   = y;
    e.ovf = ovf;
    e.cc  = CC_EN ? {zf, sf, of_} : 3'b000;
    q.push_back(e);
  endtask

  // Monitor: the handshake completes at the following posedge
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
        chk("rsp_y", rsp_y, e.y);
        chk("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, e.ovf});
        chk("cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, e.cc});
      end
    end
  end

  task automatic drive(input int r, input logic v, input logic [1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (r == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic wait_ready(input int r, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((r == 0) ? req0_ready : req1_ready) && n < 20);
    if (!((r == 0) ? req0_ready : req1_ready)) chk(name, 64'd0, 64'd1);
  endtask

  // One transaction with rsp_ready held high, checking the two-edge latency.
  task automatic issue(input int r, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] y, input logic ovf,
                       input logic zf, input logic sf, input logic of_);
    @(posedge clk); #1;
    drive(r, 1'b1, op, a, b);
    push(r[0], y, ovf, zf, sf, of_);
    wait_ready(r, "grant_timeout");
    @(posedge clk); #1;
    drive(r, 1'b0, op, a, b);
    @(negedge clk);
    chk("lat_exec", {62'd0, busy, rsp_valid}, 64'd2);
    @(negedge clk);
    chk("lat_resp", {63'd0, rsp_valid}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] snap_y;
    logic [1:0]   snap_f;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    drive(0, 1'b0, 2'd0, '0, '0);
    drive(1, 1'b0, 2'd0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_busy", {62'd0, rsp_valid, busy}, 64'd0);
    chk("rst_y", rsp_y, 64'd0);
    chk("rst_ovf_id", {62'd0, rsp_ovf, rsp_id}, 64'd0);
    chk("rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd0);
    chk("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while a result is waiting in RESP: the result is discarded.
    @(posedge clk); #1;
    drive(0, 1'b1, 2'd3, 64'hFF00, 64'h0FF0);
    wait_ready(0, "grant_timeout");
    @(negedge clk);
    @(negedge clk);
    chk("mid_resp_valid", {63'd0, rsp_valid}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_busy", {62'd0, rsp_valid, busy}, 64'd0);
    chk("mid_rst_y", rsp_y, 64'd0);
    chk("mid_rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready0", {63'd0, req0_ready}, 64'd1);
    push(1'b0, 64'hF0F0, 1'b0, 1'b0, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);

    issue(0, 2'd0, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000,
          1'b1, 1'b0, 1'b1, 1'b1);
    issue(0, 2'd1, 64'd3, 64'd3, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(0, 2'd3, 64'hFF00, 64'h0FF0, 64'hF0F0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(1, 2'd2, 64'hFF00, 64'h0FF0, 64'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Round-robin: prio is 0 after the last req1 grant, so req0 goes first.
    @(posedge clk); #1;
    drive(0, 1'b1, 2'd0, 64'd1, 64'd2);
    drive(1, 1'b1, 2'd1, 64'd1, 64'd2);
    for (int i = 0; i < 2; i++) begin
      push(1'b0, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      push(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("rr_ready_c%0d", i), {62'd0, req0_ready, req1_ready},
          (i % 6 == 0) ? 64'd2 : ((i % 6 == 3) ? 64'd1 : 64'd0));
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Backpressure with req1 still requesting.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive(1, 1'b1, 2'd1, 64'h8000_0000_0000_0000, 64'd1);
    push(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_ready(1, "grant_timeout");
    @(posedge clk); #1;
    drive(1, 1'b1, 2'd2, 64'hFF00, 64'h0FF0);
    push(1'b1, 64'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
    snap_y = rsp_y;
    snap_f = {rsp_id, rsp_ovf};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_c%0d", i), {60'd0, rsp_valid, req1_ready, rsp_id, rsp_ovf},
          {60'd0, 1'b1, 1'b0, snap_f});
      chk($sformatf("bp_y_c%0d", i), rsp_y, snap_y);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready1_hs", {63'd0, req1_ready}, 64'd0);
    @(negedge clk);
    chk("bp_ready1_after", {63'd0, req1_ready}, 64'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (4) @(negedge clk);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
